// File: rtl/fft_mult_pkg.sv
// Shared constants, the two's-complement magnitude helper and the response record for the FFT multiplier share.
// Pure definitions: no latency, no flow control.
package fft_mult_pkg;

  localparam int N_DEF    = 16;
  localparam int Q_DEF    = 8;
  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = $clog2(NREQ_DEF);
  localparam int MAGW     = 64;

  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic [N_DEF-1:0]   data;
  } rsp_t;

  // Callers sign-extend into MAGW bits, so the most negative N-bit value yields 2^(N-1) cleanly.
  function automatic logic [MAGW-1:0] twos_mag(input logic [MAGW-1:0] v);
    return v[MAGW-1] ? (~v + MAGW'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_qmul_pipe.sv
// Signed Q-format sign-magnitude multiply (truncate toward zero) plus an MUL_LAT-deep valid/id/data pipe; optional clamp under MULT_ARB_SAT_EN.
// Latency MUL_LAT cycles from accepted operands to vld_o; no backpressure, the pipe always advances.
module qmul_pipe
  import fft_mult_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int Q       = Q_DEF,
  parameter int MUL_LAT = 2,
  parameter int IDW     = IDW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vld_i,
  input  logic [IDW-1:0] id_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           vld_o,
  output logic [IDW-1:0] id_o,
  output logic [N-1:0]   data_o
`ifdef MULT_ARB_SAT_EN
  ,
  output logic           sat_o
`endif
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   data;
  } stage_t;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] prod;
  logic [N-1:0]   m;
  logic [N-1:0]   res;
  logic           neg;

  assign mag_a = N'(twos_mag(MAGW'($signed(a_i))));
  assign mag_b = N'(twos_mag(MAGW'($signed(b_i))));
  assign prod  = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
  assign m     = N'(prod >> Q);
  assign neg   = a_i[N-1] ^ b_i[N-1];

`ifdef MULT_ARB_SAT_EN
  localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_MAX = {1'b1, {(N-2){1'b0}}, 1'b1};

  logic ovf;
  logic sat_q;

  // Any magnitude bit at or above the result sign position means the signed range is exceeded.
  assign ovf = |(prod >> (N-1+Q));

  always_comb begin
    if (ovf) res = neg ? NEG_MAX : POS_MAX;
    else     res = neg ? (~m + N'(1)) : m;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_q | (vld_i & ovf);
  end

  assign sat_o = sat_q;
`else
  assign res = neg ? (~m + N'(1)) : m;
`endif

  stage_t             pipe_q [MUL_LAT];
  logic [MUL_LAT-1:0] vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < MUL_LAT; s++) pipe_q[s] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) pipe_q[0] <= '{id: id_i, data: res};
      for (int s = 1; s < MUL_LAT; s++) begin
        vld_q[s]  <= vld_q[s-1];
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  assign vld_o  = vld_q[MUL_LAT-1];
  assign id_o   = pipe_q[MUL_LAT-1].id;
  assign data_o = pipe_q[MUL_LAT-1].data;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one pipelined Q-format multiplier among NREQ requesters; responses tagged by id, MUL_LAT cycles after transfer.
// Grant is combinational, one per cycle; no response backpressure. MULT_ARB_SAT_EN adds clamping and the sticky sat_flag port.
module mult_share_arbiter
  import fft_mult_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int Q       = Q_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int MUL_LAT = 2,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*N-1:0]            req_a,
  input  logic [NREQ*N-1:0]            req_b,
  output logic [NREQ-1:0]              req_ready,
  output logic                         rsp_valid,
  output logic [IDW-1:0]               rsp_id,
  output logic [N-1:0]                 rsp_data,
  output logic [$clog2(MUL_LAT+1)-1:0] inflight
`ifdef MULT_ARB_SAT_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam int CW = $clog2(MUL_LAT+1);

  logic [IDW-1:0]  last_q;
  logic [IDW-1:0]  last_d;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  idx;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   inflight_d;

  // Scan starts just past the last winner, so the last winner is considered last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    xfer   = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (!xfer && req_valid[idx]) begin
        xfer     = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*N +: N];
        b_sel = req_b[i*N +: N];
      end
    end
  end

  assign req_ready = gnt;
  assign last_d    = xfer ? gnt_id : last_q;

  always_comb begin
    inflight_d = inflight_q;
    case ({xfer, rsp_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= IDW'(NREQ-1);
      inflight_q <= '0;
    end else begin
      last_q     <= last_d;
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;

  qmul_pipe #(
    .N       (N),
    .Q       (Q),
    .MUL_LAT (MUL_LAT),
    .IDW     (IDW)
  ) u_qmul_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (xfer),
    .id_i   (gnt_id),
    .a_i    (a_sel),
    .b_i    (b_sel),
    .vld_o  (rsp_valid),
    .id_o   (rsp_id),
    .data_o (rsp_data)
`ifdef MULT_ARB_SAT_EN
    ,
    .sat_o  (sat_flag)
`endif
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter at N=16, Q=8, NREQ=4, MUL_LAT=2.
module tb_mult_share_arbiter;

  localparam int N    = 16;
  localparam int Q    = 8;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_data;
  logic [1:0]        inflight;
`ifdef MULT_ARB_SAT_EN
  logic              sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  mult_share_arbiter #(
    .N(N), .Q(Q), .NREQ(NREQ), .MUL_LAT(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .inflight  (inflight)
`ifdef MULT_ARB_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    int exp_inf;
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ready got %b want 0001", req_ready); end
`ifdef MULT_ARB_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, 4'(1 << (k % 4))); end
      exp_inf = (k == 0) ? 0 : (k == 1) ? 1 : 2;
      checks++;
      if (int'(inflight) != exp_inf) begin errors++; $display("FAIL rr_inflight[%0d] got %0d want %0d", k, inflight, exp_inf); end
      checks++;
      if (rsp_valid !== (k >= 2)) begin errors++; $display("FAIL rr_rsp_valid[%0d] got %b want %b", k, rsp_valid, k >= 2); end
      if (k >= 2) begin
        checks++;
        if (int'(rsp_id) != (k - 2) % 4) begin errors++; $display("FAIL rr_rsp_id[%0d] got %0d want %0d", k, rsp_id, (k - 2) % 4); end
      end
      @(negedge clk); #1;
    end
    req_valid = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_inf = 2 - k;
      checks++;
      if (int'(inflight) != exp_inf) begin errors++; $display("FAIL drain_inflight[%0d] got %0d want %0d", k, inflight, exp_inf); end
      checks++;
      if (rsp_valid !== (k < 2)) begin errors++; $display("FAIL drain_rsp_valid[%0d] got %b want %b", k, rsp_valid, k < 2); end
      if (k < 2) begin
        checks++;
        if (int'(rsp_id) != ((k == 0) ? 3 : 0)) begin errors++; $display("FAIL drain_rsp_id[%0d] got %0d want %0d", k, rsp_id, (k == 0) ? 3 : 0); end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_overflow;
    logic [15:0] exp_d;
`ifdef MULT_ARB_SAT_EN
    exp_d = 16'h7FFF;
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL ovf_sat_before got %b want 0", sat_flag); end
`else
    exp_d = 16'hFF00;
`endif
    req_valid = 4'b0100; req_a = '0; req_b = '0;
    req_a[2*N +: N] = 16'h7FFF; req_b[2*N +: N] = 16'h7FFF;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ovf_ready got %b want 0100", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ovf_early_rsp got %b want 0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ovf_rsp_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL ovf_rsp_id got %0d want 2", rsp_id); end
    checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL ovf_rsp_data got %h want %h", rsp_data, exp_d); end
`ifdef MULT_ARB_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL ovf_sat_after got %b want 1", sat_flag); end
`endif
    @(negedge clk); #1;
  endtask

  task automatic test_arith;
    logic [1:0]  t_id  [6];
    logic [15:0] t_a   [6];
    logic [15:0] t_b   [6];
    logic [15:0] t_exp [6];
    t_id[0] = 1; t_a[0] = 16'h0180; t_b[0] = 16'h0200; t_exp[0] = 16'h0300;
    t_id[1] = 1; t_a[1] = 16'hFE80; t_b[1] = 16'h0200; t_exp[1] = 16'hFD00;
    t_id[2] = 1; t_a[2] = 16'hFE80; t_b[2] = 16'hFE00; t_exp[2] = 16'h0300;
    t_id[3] = 2; t_a[3] = 16'h0001; t_b[3] = 16'hFF80; t_exp[3] = 16'h0000;
    t_id[4] = 0; t_a[4] = 16'hFF00; t_b[4] = 16'hFF00; t_exp[4] = 16'h0100;
`ifdef MULT_ARB_SAT_EN
    t_id[5] = 3; t_a[5] = 16'h8000; t_b[5] = 16'h0100; t_exp[5] = 16'h8001;
`else
    t_id[5] = 3; t_a[5] = 16'h8000; t_b[5] = 16'h0100; t_exp[5] = 16'h8000;
`endif
    for (int t = 0; t < 6; t++) begin
      req_a = '0; req_b = '0;
      req_a[int'(t_id[t])*N +: N] = t_a[t];
      req_b[int'(t_id[t])*N +: N] = t_b[t];
      req_valid = 4'(1 << t_id[t]);
      #1;
      checks++; if (req_ready !== 4'(1 << t_id[t])) begin errors++; $display("FAIL arith_ready[%0d] got %b want %b", t, req_ready, 4'(1 << t_id[t])); end
      @(negedge clk); req_valid = '0; #1;
      checks++; if (rsp_valid !== 1'b0 || inflight !== 2'd1) begin errors++; $display("FAIL arith_early[%0d] got vld=%b inf=%0d want vld=0 inf=1", t, rsp_valid, inflight); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL arith_rsp_valid[%0d] got %b want 1", t, rsp_valid); end
      checks++; if (rsp_id !== t_id[t]) begin errors++; $display("FAIL arith_rsp_id[%0d] got %0d want %0d", t, rsp_id, t_id[t]); end
      checks++; if (rsp_data !== t_exp[t]) begin errors++; $display("FAIL arith_rsp_data[%0d] got %h want %h", t, rsp_data, t_exp[t]); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || inflight !== 2'd0) begin errors++; $display("FAIL arith_pulse_end[%0d] got vld=%b inf=%0d want vld=0 inf=0", t, rsp_valid, inflight); end
    end
  endtask

  task automatic test_fairness;
    int gs [6];
    int q [$];
    int want;
    gs[0] = 0; gs[1] = 2; gs[2] = 3; gs[3] = 0; gs[4] = 2; gs[5] = 0;
    rst = 1'b1; req_valid = '0;
    @(negedge clk); rst = 1'b0; #1;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) req_valid = 4'b0101 | ((c == 2) ? 4'b1000 : 4'b0000);
      else       req_valid = '0;
      #1;
      if (c < 6) begin
        checks++;
        if (req_ready !== 4'(1 << gs[c])) begin errors++; $display("FAIL fair_grant[%0d] got %b want %b", c, req_ready, 4'(1 << gs[c])); end
        q.push_back(gs[c]);
      end
      checks++;
      if (int'(inflight) > LAT) begin errors++; $display("FAIL fair_inflight_max[%0d] got %0d want <=%0d", c, inflight, LAT); end
      if (rsp_valid === 1'b1) begin
        want = (q.size() > 0) ? q[0] : -1;
        if (q.size() > 0) void'(q.pop_front());
        checks++;
        if (int'(rsp_id) != want) begin errors++; $display("FAIL fair_rsp_order[%0d] got %0d want %0d", c, rsp_id, want); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL fair_drain_inflight got %0d want 0", inflight); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL fair_missing_rsp got %0d outstanding want 0", q.size()); end
  endtask

  task automatic test_reset_midop;
    req_valid = 4'b0010; req_a = '0; req_b = '0;
    req_a[N +: N] = 16'h0100; req_b[N +: N] = 16'h0100;
    repeat (2) @(negedge clk);
    req_valid = '0; #1;
    checks++; if (inflight !== 2'd2) begin errors++; $display("FAIL midop_inflight_before got %0d want 2", inflight); end
    rst = 1'b1; #1;
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL midop_inflight_rst got %0d want 0", inflight); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_rsp_rst got %b want 0", rsp_valid); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_ghost_rsp[%0d] got %b want 0", c, rsp_valid); end
      @(negedge clk);
    end
    req_valid = '1; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midop_first_grant got %b want 0001", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL midop_rsp got vld=%b id=%0d want vld=1 id=0", rsp_valid, rsp_id); end
  endtask

  initial begin
    test_reset;
    test_overflow;
    test_arith;
    test_fairness;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one pipelined signed fixed-point multiplier among NREQ requesters. Requesters are the butterfly twiddle-multiply ports of the 32-point DIT FFT.
- Work-conserving round-robin arbitration, with at most one operand pair issued per cycle.
- Each result returns on a common response bus, tagged with the requester ID, after exactly MUL_LAT cycles.
- Sits between the butterfly units and the fixed-point multiply datapath. Lets stages time-multiplex one multiplier instead of instantiating one per butterfly.

Parameters:
- N, 16, operand/result width (two's complement).
- Q, 8, fractional bits (QN-Q.Q format).
- NREQ, 4, number of requesters (≥2).
- MUL_LAT, 2, issue-to-response latency in cycles (≥1).
- IDW, $clog2(NREQ), requester-ID width.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- req_valid, in, NREQ, per-requester operand-valid.
- req_a, in, NREQ*N, packed operand A; slice i belongs to requester i.
- req_b, in, NREQ*N, packed operand B.
- req_ready, out, NREQ, one-hot grant (combinational from req_valid and the RR pointer).
- rsp_valid, out, 1, result valid (single-cycle pulse per accepted request).
- rsp_id, out, IDW, requester ID of the result.
- rsp_data, out, N, product in Q format.
- inflight, out, $clog2(MUL_LAT+1), number of accepted, not-yet-returned operations.

Behaviour:
- Reset (async):
  - rsp_valid=0, rsp_id=0, rsp_data=0, inflight=0.
  - All pipeline valid bits cleared.
  - RR pointer set so that requester 0 has highest priority.
- Reset mid-operation: in-flight results are discarded and never emitted.
- Arbitration:
  - Grant = first asserted req_valid[i] scanning from (last_granted+1) mod NREQ upward, with wrap.
  - req_ready is one-hot, or zero when no req_valid is asserted.
  - req_ready is never asserted for a requester whose req_valid is low.
  - Transfer occurs when req_valid[i] & req_ready[i] are high at a rising edge.
  - The pointer updates only on a transfer. Idle cycles do not move it.
- Requester rules:
  - A requester holds req_a/req_b stable while req_valid is high and ready is low.
  - A requester may drop valid without a transfer; the arbiter tolerates this.
- No response backpressure: the consumer must always accept rsp_*. Throughput is 1 op/cycle sustained.
- Latency: a transfer at edge t produces rsp_valid=1 with matching rsp_id/rsp_data in the cycle after edge t+MUL_LAT-1. With MUL_LAT=1, the response is visible in the cycle right after the transfer. Responses return in issue order.
- Arithmetic (sign-magnitude, truncation toward zero):
  - |A|, |B| = two's-complement negation if MSB set. -2^(N-1) maps to unsigned magnitude 2^(N-1).
  - P = |A|*|B| (2N bits unsigned). M = P[N-1+Q:Q].
  - Result = M if sign(A)==sign(B), else (~M+1) mod 2^N.
  - The product is computed in stage 1; later stages only delay it.
- inflight:
  - +1 on a transfer, -1 on rsp_valid, unchanged when both happen in the same cycle.
  - Never exceeds MUL_LAT.
- Simultaneous transfer and response in the same cycle is legal and normal.
- Single requester asserted continuously is granted every cycle.

Optional Feature:
- Macro: MULT_ARB_SAT_EN.
- Defined:
  - If the magnitude product overflows the N-bit signed range (P[2N-1:N-1+Q] nonzero, or M[N-1] set), the result clamps.
  - Same-sign clamps to 2^(N-1)-1; opposite-sign clamps to -(2^(N-1)-1).
  - An extra sticky output sat_flag (1 bit, reset 0) sets on any clamp.
- Undefined: plain truncation and wrap as above; sat_flag port absent.

Decomposition:
- Package fft_mult_pkg:
  - Default N/Q constants.
  - Helper function for two's-complement magnitude.
  - Typedef for the response struct {id, data}.
- One natural sub-module: qmul_pipe. It holds the signed Q-format multiply plus MUL_LAT-stage valid/ID/data shift register. The arbiter wraps it together with the RR grant logic.

Test Plan:
- Reset with all req_valid=1, then release → first grant is req0. Continuous grants follow 0,1,2,3,0. No rsp_valid before MUL_LAT cycles after the first transfer.
- Req1 issues 0x0180 × 0x0200 (1.5×2.0) → rsp_id=1, rsp_data=0x0300 exactly MUL_LAT cycles later. Repeat with 0xFE80 × 0x0200 → 0xFD00 and 0xFE80 × 0xFE00 → 0x0300.
- Truncation toward zero: 0x0001 × 0xFF80 → 0x0000, not 0xFFFF.
- Overflow: 0x7FFF × 0x7FFF → 0xFF00 without MULT_ARB_SAT_EN. With it defined → 0x7FFF and sat_flag=1.
- Fairness: req0 and req2 held valid, req3 pulsed once mid-stream → grant order 0,2,3,0,2… (order after the last grant), inflight ≤ MUL_LAT throughout, and inflight returns to 0 after the traffic drains.
- Assert rst while 2 ops are in flight → rsp_valid stays 0 and inflight=0 immediately. The next request after release is served by req0 priority.
